// File: rtl/sramsp_req_ctrl.sv
// Request/response front-end for the single-port SRAM wrapper.
// Drives macro pins from a valid/ready request stream and queues read data.
module sramsp_req_ctrl #(
    parameter int          WORDSWD   = 13,
    parameter int          BITS      = 128,
    parameter int          RSP_DEPTH = 2,
    parameter logic [2:0]  EMA_VAL   = 3'b011,
    parameter logic [1:0]  EMAW_VAL  = 2'b01
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [WORDSWD-1:0] req_addr,
    input  logic [BITS-1:0]    req_wdata,
    input  logic [BITS-1:0]    req_wmask,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [BITS-1:0]    rsp_rdata,
    output logic               sram_cen,
    output logic               sram_gwen,
    output logic [BITS-1:0]    sram_wen,
    output logic [WORDSWD-1:0] sram_a,
    output logic [BITS-1:0]    sram_d,
    input  logic [BITS-1:0]    sram_q,
    output logic [2:0]         sram_ema,
    output logic [1:0]         sram_emaw,
    output logic               sram_tie
);

    // count holds 0..RSP_DEPTH; occ needs one extra bit for the in-flight read
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int OW = CW + 1;

    logic [BITS-1:0] mem     [RSP_DEPTH];
    logic [BITS-1:0] mem_nxt [RSP_DEPTH];
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic [CW-1:0]   wr_idx;
    logic            rd_inflight;
    logic [OW-1:0]   occ;
    logic [OW-1:0]   occ_after_pop;
    logic            rd_ok;
    logic            accept;
    logic            wr_acc;
    logic            rd_acc;
    logic            push;
    logic            pop;

    // Constant macro configuration and functional-mode test-pin level
    assign sram_ema  = EMA_VAL;
    assign sram_emaw = EMAW_VAL;
    assign sram_tie  = 1'b1;

    // Credit accounting: a pop this cycle frees a slot for a read
    // accepted this same cycle, keeping single-cycle read throughput.
    assign pop           = rsp_valid && rsp_ready;
    assign push          = rd_inflight;
    assign occ           = OW'(count) + OW'(rd_inflight);
    assign occ_after_pop = occ - OW'(pop);
    assign rd_ok         = occ_after_pop < OW'(RSP_DEPTH);

    // Writes never produce a response, so they bypass the credit check
    assign req_ready = !RST && (req_we || rd_ok);
    assign accept    = req_valid && req_ready;
    assign wr_acc    = accept && req_we;
    assign rd_acc    = accept && !req_we;

    // Pins are combinational so the macro samples at the accepting edge
    assign sram_cen  = !accept;
    assign sram_gwen = !wr_acc;
    assign sram_wen  = wr_acc ? ~req_wmask : {BITS{1'b1}};
    assign sram_a    = req_addr;
    assign sram_d    = req_wdata;

    // Slot 0 is the FIFO head and doubles as the registered response data
    assign rsp_valid = count != '0;
    assign rsp_rdata = mem[0];
    assign wr_idx    = count - CW'(pop);
    assign count_nxt = count + CW'(push) - CW'(pop);

    // Shift-on-pop FIFO update, then place captured Q behind the live entries
    always_comb begin
        for (int i = 0; i < RSP_DEPTH; i++) begin
            mem_nxt[i] = mem[i];
        end
        if (pop) begin
            for (int i = 0; i < RSP_DEPTH - 1; i++) begin
                mem_nxt[i] = mem[i+1];
            end
            mem_nxt[RSP_DEPTH-1] = '0;
        end
        if (push) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                if (CW'(i) == wr_idx) begin
                    mem_nxt[i] = sram_q;
                end
            end
        end
    end

    // Q is valid the cycle after a read is accepted
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_inflight <= 1'b0;
        end else begin
            rd_inflight <= rd_acc;
        end
    end

    // FIFO storage and occupancy
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            count <= count_nxt;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem[i] <= mem_nxt[i];
            end
        end
    end

    // Outstanding reads plus queued data can never exceed the FIFO
    a_no_overflow : assert property (
        @(posedge CLK) disable iff (RST) occ <= OW'(RSP_DEPTH)
    );

    // A push into a full FIFO without a pop would lose read data
    a_no_push_full : assert property (
        @(posedge CLK) disable iff (RST)
        !(push && !pop && count == CW'(RSP_DEPTH))
    );

endmodule

// File: tb/tb_sramsp_req_ctrl.sv
// Bench for sramsp_req_ctrl with a behavioural 1-cycle-latency SRAM.
// Read responses are checked against a scoreboard of expected data.
module tb_sramsp_req_ctrl;

    localparam int AW = 13;
    localparam int DW = 128;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [DW-1:0] req_wmask = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q = '0;
    logic [2:0]    sram_ema;
    logic [1:0]    sram_emaw;
    logic          sram_tie;

    int n_chk = 0;
    int n_err = 0;

    logic [DW-1:0] sram_mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem  [0:(1<<AW)-1];
    logic [DW-1:0] sb [$];

    sramsp_req_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .sram_cen  (sram_cen),
        .sram_gwen (sram_gwen),
        .sram_wen  (sram_wen),
        .sram_a    (sram_a),
        .sram_d    (sram_d),
        .sram_q    (sram_q),
        .sram_ema  (sram_ema),
        .sram_emaw (sram_emaw),
        .sram_tie  (sram_tie)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // Behavioural macro: bit-masked write, registered read data
    always @(posedge CLK) begin
        if (!sram_cen) begin
            if (!sram_gwen)
                sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen)
                                  | (sram_d & ~sram_wen);
            else
                sram_q <= sram_mem[sram_a];
        end
    end

    // Scoreboard: reference memory tracks accepted writes, reads enqueue
    always @(negedge CLK) begin
        if (RST) begin
            sb.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 128'd1, 128'd0);
                end else begin
                    chk("rsp_data", rsp_rdata, sb.pop_front());
                end
            end
            if (req_valid && req_ready) begin
                if (req_we)
                    ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask)
                                      | (req_wdata & req_wmask);
                else
                    sb.push_back(ref_mem[req_addr]);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] m);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
    endtask

    logic [DW-1:0] all1;
    logic [DW-1:0] mask;
    logic [5:0]    vbits;
    bit            seen;

    initial begin
        all1 = '1;
        for (int i = 0; i < (1 << AW); i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end

        // Reset state with a read offered
        drive(1'b1, 1'b0, 13'h005, '0, '0);
        @(negedge CLK);
        chk("rst_ready", {127'd0, req_ready}, 128'd0);
        chk("rst_cen", {127'd0, sram_cen}, 128'd1);
        chk("rst_gwen", {127'd0, sram_gwen}, 128'd1);
        chk("rst_wen", sram_wen, all1);
        chk("rst_rvalid", {127'd0, rsp_valid}, 128'd0);
        chk("rst_rdata", rsp_rdata, 128'd0);
        step();
        drive(1'b0, 1'b0, '0, '0, '0);
        RST = 1'b0;
        step();

        // Write then read same address: response two cycles after the read
        drive(1'b1, 1'b1, 13'h010, {16{8'hA5}}, all1);
        @(negedge CLK);
        chk("wr_ready", {127'd0, req_ready}, 128'd1);
        chk("wr_cen", {127'd0, sram_cen}, 128'd0);
        chk("wr_gwen", {127'd0, sram_gwen}, 128'd0);
        chk("wr_wen", sram_wen, 128'd0);
        step();
        drive(1'b1, 1'b0, 13'h010, '0, '0);
        @(negedge CLK);
        chk("rd_ready", {127'd0, req_ready}, 128'd1);
        chk("rd_gwen", {127'd0, sram_gwen}, 128'd1);
        chk("rd_wen", sram_wen, all1);
        step();
        drive(1'b0, 1'b0, '0, '0, '0);
        @(negedge CLK);
        chk("lat_t2", {127'd0, rsp_valid}, 128'd0);
        step();
        @(negedge CLK);
        chk("lat_t3", {127'd0, rsp_valid}, 128'd1);
        chk("wr_rd_data", rsp_rdata, {16{8'hA5}});
        step();
        @(negedge CLK);
        chk("lat_t4", {127'd0, rsp_valid}, 128'd0);

        // Preload 0..3, then stream four reads back to back
        for (int i = 0; i < 4; i++) begin
            step();
            drive(1'b1, 1'b1, AW'(i), {4{32'h1000_0000 + 32'(i)}}, all1);
        end
        step();
        vbits = '0;
        for (int c = 0; c < 6; c++) begin
            if (c < 4) drive(1'b1, 1'b0, AW'(c), '0, '0);
            else drive(1'b0, 1'b0, '0, '0, '0);
            @(negedge CLK);
            if (c < 4) chk("strm_ready", {127'd0, req_ready}, 128'd1);
            vbits[c] = rsp_valid;
            step();
        end
        chk("strm_vpat", {122'd0, vbits}, {122'd0, 6'b111100});

        // Backpressure: two reads fill credits, third waits, writes pass
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 13'h001, '0, '0);
        @(negedge CLK);
        chk("bp_rd0", {127'd0, req_ready}, 128'd1);
        step();
        drive(1'b1, 1'b0, 13'h002, '0, '0);
        @(negedge CLK);
        chk("bp_rd1", {127'd0, req_ready}, 128'd1);
        step();
        drive(1'b1, 1'b0, 13'h003, '0, '0);
        @(negedge CLK);
        chk("bp_rd2_blk", {127'd0, req_ready}, 128'd0);
        chk("bp_rd2_cen", {127'd0, sram_cen}, 128'd1);
        step();
        drive(1'b1, 1'b1, 13'h020, {8{16'h5A3C}}, all1);
        @(negedge CLK);
        chk("bp_wr_ready", {127'd0, req_ready}, 128'd1);
        chk("bp_wr_gwen", {127'd0, sram_gwen}, 128'd0);
        step();
        drive(1'b1, 1'b0, 13'h003, '0, '0);
        @(negedge CLK);
        chk("bp_rd2_still", {127'd0, req_ready}, 128'd0);
        chk("bp_hold_v", {127'd0, rsp_valid}, 128'd1);
        chk("bp_hold_d", rsp_rdata, {4{32'h1000_0001}});
        step();
        rsp_ready = 1'b1;
        @(negedge CLK);
        chk("bp_rd2_go", {127'd0, req_ready}, 128'd1);
        step();
        drive(1'b0, 1'b0, '0, '0, '0);
        for (int c = 0; c < 5; c++) step();

        // Masked write over an all-ones word
        mask = {8{16'h00FF}};
        drive(1'b1, 1'b1, 13'h030, all1, all1);
        step();
        drive(1'b1, 1'b1, 13'h030, '0, mask);
        @(negedge CLK);
        chk("mw_wen", sram_wen, ~mask);
        step();
        drive(1'b1, 1'b0, 13'h030, '0, '0);
        step();
        drive(1'b0, 1'b0, '0, '0, '0);
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge CLK);
            if (rsp_valid) begin
                seen = 1'b1;
                chk("mw_rdata", rsp_rdata, {8{16'hFF00}});
            end
            step();
        end
        chk("mw_seen", {127'd0, seen}, 128'd1);

        // Reset while a read is in flight
        drive(1'b1, 1'b0, 13'h010, '0, '0);
        step();
        RST = 1'b1;
        @(negedge CLK);
        chk("mr_ready", {127'd0, req_ready}, 128'd0);
        chk("mr_cen", {127'd0, sram_cen}, 128'd1);
        chk("mr_v0", {127'd0, rsp_valid}, 128'd0);
        step();
        @(negedge CLK);
        chk("mr_v1", {127'd0, rsp_valid}, 128'd0);
        step();
        drive(1'b0, 1'b0, '0, '0, '0);
        RST = 1'b0;
        vbits = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            vbits[c] = rsp_valid;
            step();
        end
        chk("mr_after", {122'd0, vbits}, 128'd0);

        // Idle: macro deselected, ties at functional values
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            chk("idle_cen", {127'd0, sram_cen}, 128'd1);
            chk("idle_tie", {123'd0, sram_tie, sram_ema, sram_emaw},
                {123'd0, 1'b1, 3'b011, 2'b01});
            step();
        end

        chk("sb_drained", 128'(sb.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
